// File: rtl/mem_access_stage.sv
// mem_access_stage: memory (M) stage of the 8-bit pipelined processor.
//
// Samples the EX/MEM bundle every cycle while idle. ALU-only instructions
// pass through with one cycle of latency. Loads and stores are captured,
// issued on a req/ack handshake with variable latency, and presented one
// cycle after the ack. Upstream is stalled while an access is outstanding.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that has not
// been acked after TIMEOUT request cycles (mem_err pulses, the instruction
// retires without a register write). Without it, requests wait forever and
// mem_err is tied low.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   valid_E, flush_M                 live instruction / squash it
//   rd_en_E, wr_en_mem_E             load / store request
//   wr_en_regf_E, mux_out_sel_E,
//   mux_rdata_sel_E, out_port_sel_E  write-back control bits
//   rd_E, alu_out_E, RD2_E,
//   instr_E, IN_PORT_E               EX/MEM data bundle
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ack, mem_rdata    data-memory handshake
//   stall_M                          hold EX/MEM and earlier stages
//   valid_M ... IN_PORT_M            registered bundle to MEM/WB
//   mem_err                          timeout pulse
module mem_access_stage #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_E,
   input  logic              flush_M,
   input  logic              rd_en_E,
   input  logic              wr_en_mem_E,
   input  logic              wr_en_regf_E,
   input  logic              mux_out_sel_E,
   input  logic              mux_rdata_sel_E,
   input  logic              out_port_sel_E,
   input  logic [1:0]        rd_E,
   input  logic [15:0]       alu_out_E,
   input  logic [15:0]       RD2_E,
   input  logic [15:0]       instr_E,
   input  logic [7:0]        IN_PORT_E,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata,
   output logic              stall_M,
   output logic              valid_M,
   output logic              wr_en_regf_M,
   output logic              mux_out_sel_M,
   output logic              mux_rdata_sel_M,
   output logic              out_port_sel_M,
   output logic              rd_en_M,
   output logic [1:0]        ADDER_M,
   output logic [15:0]       read_data_M,
   output logic [15:0]       alu_out_M,
   output logic [15:0]       instr_M,
   output logic [15:0]       RD2_M,
   output logic [7:0]        IN_PORT_M,
   output logic              mem_err
);

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_access_stage: TIMEOUT must be in 1..255");
   end
   if (ADDR_W < 1 || ADDR_W > 16) begin : g_bad_addr_w
      $error("mem_access_stage: ADDR_W must be in 1..16");
   end

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StReq  = 1'b1;

   logic [0:0]  state_q, state_d;
   logic        valid_q, valid_d;
   // Raw control bits; masked by valid_q on the way out so invalid cycles are bubbles.
   logic        wr_en_regf_q, wr_en_regf_d;
   logic        mux_out_sel_q, mux_out_sel_d;
   logic        mux_rdata_sel_q, mux_rdata_sel_d;
   logic        out_port_sel_q, out_port_sel_d;
   logic        rd_en_q, rd_en_d;
   logic        we_q, we_d;
   logic [1:0]  rd_q, rd_d;
   logic [15:0] alu_q, alu_d;
   logic [15:0] rd2_q, rd2_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] rdata_q, rdata_d;
   logic [7:0]  in_port_q, in_port_d;

   logic live;
   logic mem_op;
   logic timeout;

   assign live   = valid_E & ~flush_M;
   assign mem_op = live & (rd_en_E | wr_en_mem_E);

`ifdef MEM_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       err_q;

   // cnt_q equals the number of REQ cycles already spent without an ack.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StIdle) begin
         cnt_d = 8'd0;
      end else if (!mem_ack) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   assign timeout = (state_q == StReq) && (cnt_q == 8'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= timeout & ~mem_ack;
      end
   end

   assign mem_err = err_q;
`else
   assign timeout = 1'b0;
   assign mem_err = 1'b0;
`endif

   always_comb begin
      state_d         = state_q;
      valid_d         = 1'b0;
      wr_en_regf_d    = wr_en_regf_q;
      mux_out_sel_d   = mux_out_sel_q;
      mux_rdata_sel_d = mux_rdata_sel_q;
      out_port_sel_d  = out_port_sel_q;
      rd_en_d         = rd_en_q;
      we_d            = we_q;
      rd_d            = rd_q;
      alu_d           = alu_q;
      rd2_d           = rd2_q;
      instr_d         = instr_q;
      rdata_d         = rdata_q;
      in_port_d       = in_port_q;
      case (state_q)
         StIdle: begin
            wr_en_regf_d    = wr_en_regf_E;
            mux_out_sel_d   = mux_out_sel_E;
            mux_rdata_sel_d = mux_rdata_sel_E;
            out_port_sel_d  = out_port_sel_E;
            // Load+store together behaves as a store only.
            rd_en_d         = rd_en_E & ~wr_en_mem_E;
            we_d            = wr_en_mem_E;
            rd_d            = rd_E;
            alu_d           = alu_out_E;
            rd2_d           = RD2_E;
            instr_d         = instr_E;
            in_port_d       = IN_PORT_E;
            rdata_d         = 16'h0000;
            valid_d         = live & ~mem_op;
            if (mem_op) begin
               state_d = StReq;
            end
         end
         StReq: begin
            // Ack wins over an expiring timeout in the same cycle.
            if (mem_ack) begin
               state_d = StIdle;
               valid_d = 1'b1;
               rdata_d = rd_en_q ? mem_rdata : 16'h0000;
            end else if (timeout) begin
               state_d      = StIdle;
               valid_d      = 1'b1;
               wr_en_regf_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         valid_q         <= 1'b0;
         wr_en_regf_q    <= 1'b0;
         mux_out_sel_q   <= 1'b0;
         mux_rdata_sel_q <= 1'b0;
         out_port_sel_q  <= 1'b0;
         rd_en_q         <= 1'b0;
         we_q            <= 1'b0;
         rd_q            <= 2'd0;
         alu_q           <= 16'h0000;
         rd2_q           <= 16'h0000;
         instr_q         <= 16'h0000;
         rdata_q         <= 16'h0000;
         in_port_q       <= 8'h00;
      end else begin
         state_q         <= state_d;
         valid_q         <= valid_d;
         wr_en_regf_q    <= wr_en_regf_d;
         mux_out_sel_q   <= mux_out_sel_d;
         mux_rdata_sel_q <= mux_rdata_sel_d;
         out_port_sel_q  <= out_port_sel_d;
         rd_en_q         <= rd_en_d;
         we_q            <= we_d;
         rd_q            <= rd_d;
         alu_q           <= alu_d;
         rd2_q           <= rd2_d;
         instr_q         <= instr_d;
         rdata_q         <= rdata_d;
         in_port_q       <= in_port_d;
      end
   end

   assign stall_M   = (state_q == StReq);
   assign mem_req   = stall_M;
   assign mem_we    = stall_M & we_q;
   assign mem_addr  = stall_M ? alu_q[ADDR_W-1:0] : '0;
   assign mem_wdata = stall_M ? rd2_q : 16'h0000;

   assign valid_M         = valid_q;
   assign wr_en_regf_M    = valid_q & wr_en_regf_q;
   assign mux_out_sel_M   = valid_q & mux_out_sel_q;
   assign mux_rdata_sel_M = valid_q & mux_rdata_sel_q;
   assign out_port_sel_M  = valid_q & out_port_sel_q;
   assign rd_en_M         = valid_q & rd_en_q;
   assign ADDER_M         = rd_q;
   assign read_data_M     = rdata_q;
   assign alu_out_M       = alu_q;
   assign instr_M         = instr_q;
   assign RD2_M           = rd2_q;
   assign IN_PORT_M       = in_port_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory (M) stage of the 8-bit pipelined processor. Sits between the EX/MEM boundary and the MEM/WB register, which it feeds directly.
- Performs data-memory loads/stores over a req/ack handshake with variable latency. Stalls upstream while an access is outstanding.
- Presents the registered M-stage bundle (control bits, destination, ALU result, load data, store data, instruction, input-port byte) to MEM/WB.

Parameters:
- ADDR_W, 8, data-memory address width; address = alu_out_E[ADDR_W-1:0].
- TIMEOUT, 15, max cycles in REQ before abort (MEM_TIMEOUT_EN only); legal 1..255.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_E  in  1  EX/MEM holds a live instruction.
- flush_M  in  1  squash incoming instruction.
- rd_en_E, wr_en_mem_E  in  1 each  load / store request.
- wr_en_regf_E, mux_out_sel_E, mux_rdata_sel_E, out_port_sel_E  in  1 each  WB control bits.
- rd_E  in  2  destination register.
- alu_out_E  in  16  ALU result / memory address.
- RD2_E  in  16  store data.
- instr_E  in  16  instruction bits.
- IN_PORT_E  in  8  input-port sample.
- mem_req, mem_we  out  1 each  memory request / write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  16  store data.
- mem_ack  in  1  memory completion, 1-cycle pulse.
- mem_rdata  in  16  load data, valid with mem_ack.
- stall_M  out  1  hold EX/MEM and earlier stages.
- valid_M  out  1  output bundle live.
- wr_en_regf_M, mux_out_sel_M, mux_rdata_sel_M, out_port_sel_M, rd_en_M  out  1 each  to MEM/WB.
- ADDER_M  out  2  destination register.
- read_data_M, alu_out_M, instr_M, RD2_M  out  16 each  to MEM/WB.
- IN_PORT_M  out  8  to MEM/WB.
- mem_err  out  1  timeout pulse.

Behaviour:
- All state is updated on posedge clk. Reset is synchronous and active-high.
- Reset: state=IDLE; every output register 0; mem_req=0; stall_M=0; mem_err=0.
- FSM states are IDLE and REQ. stall_M = (state==REQ), decoded combinationally from the state register.
- IDLE, accept rule: the stage samples its inputs every cycle in IDLE.
  - valid_E=0 or flush_M=1: next cycle valid_M=0 and all control outputs 0. Data outputs still load from inputs.
  - Live instruction, no rd_en_E/wr_en_mem_E: 1-cycle latency. All outputs register their inputs, valid_M=1, read_data_M=0.
  - Live instruction, memory op: capture the whole bundle, go to REQ. valid_M=0 for that cycle.
- REQ:
  - mem_req=1; mem_we=captured wr_en_mem; mem_addr and mem_wdata are stable from the captured bundle.
  - Inputs are ignored; upstream must hold while stall_M=1.
  - On mem_ack=1, in the same cycle: load captures mem_rdata; store captures 0. Go to IDLE.
  - Next cycle: valid_M=1 with the captured bundle and read_data_M set. stall_M drops and mem_req drops.
- Minimum memory-op latency: accept N, req N+1, ack N+1, outputs valid N+2. In general, outputs are valid the cycle after ack.
- valid_M=0 in every cycle not described above. Control outputs are forced 0 whenever valid_M=0, so MEM/WB sees a bubble.
- rd_en_E and wr_en_mem_E both set: treated as store only. mem_we=1, read_data_M=0, rd_en_M=0.
- flush_M in REQ is ignored; the M-stage instruction is older than the flushing branch.
- mem_ack in IDLE is ignored.
- Reset asserted in REQ: next cycle IDLE, mem_req=0, all outputs 0. An outstanding access is abandoned.
- Reset has priority over mem_ack and flush_M in the same cycle.
- mem_addr, mem_wdata and mem_we are 0 when mem_req=0.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT with no ack: drop mem_req and go to IDLE.
  - Next cycle: mem_err=1 for one cycle; valid_M=1 with wr_en_regf_M=0 and read_data_M=0. The instruction retires without a write.
  - Ack in the same cycle as expiry: the ack wins and there is no error.
- Undefined: no counter; REQ waits indefinitely; mem_err is tied 0.

Test Plan:
- reset=1 for 2 cycles mid-traffic -> valid_M=0, all outputs 0, mem_req=0, stall_M=0.
- ALU op: valid_E=1, wr_en_regf_E=1, rd_E=2, alu_out_E=16'h00A5 -> next cycle valid_M=1, ADDER_M=2, alu_out_M=16'h00A5, stall_M never asserts.
- Load: alu_out_E=16'h0034, mem_ack on 3rd REQ cycle with mem_rdata=16'hBEEF -> mem_addr=8'h34 and stall_M high for 3 cycles; next cycle read_data_M=16'hBEEF, rd_en_M=1, valid_M=1; next queued instruction accepted the following cycle.
- Store with immediate ack: RD2_E=16'h1234, alu_out_E=16'h0010 -> one REQ cycle, mem_we=1, mem_wdata=16'h1234; then valid_M=1, wr_en_regf_M=0.
- flush_M=1 with a live load in IDLE -> no mem_req, valid_M=0. Reset during the 2nd REQ cycle -> mem_req=0 next cycle, and a late mem_ack produces no output.
- MEM_TIMEOUT_EN, TIMEOUT=4, load with no ack -> mem_req high 4 cycles, then mem_err=1 for one cycle with valid_M=1, wr_en_regf_M=0, read_data_M=0.
